// File: rtl/snes_pad_multi.sv
// snes_pad_multi
//   Reads NPADS SNES controllers that share one serial clock / latch pair.
//   A frame is started on demand (start_i) or by the optional auto-poll timer.
//   Each frame latches the pads, clocks out 16 bits per pad, and presents
//   active-high button words (1 = pressed) on vdata_o with a valid_o pulse.
//
//   Optional feature macro: SNESPAD_DEBOUNCE_EN
//     defined   : a pad word only updates when two consecutive frames agree
//     undefined : every pad word updates every frame
//
// Ports
//   clk_i     in   1         system clock
//   rst_i     in   1         synchronous, active-high reset
//   start_i   in   1         request one frame; ignored while busy_o=1
//   dclock_o  out  1         pad serial clock, idle high
//   dlatch_o  out  1         pad latch, idle low
//   sdata     in   NPADS     pad serial data, active-low, asynchronous
//   vdata_o   out  16*NPADS  button words; pad p in [16p+15:16p]
//   valid_o   out  1         1-cycle pulse while freshly refreshed vdata_o is shown
//   busy_o    out  1         frame in progress (first LATCH cycle .. DONE cycle)
module snes_pad_multi #(
  parameter int unsigned CLK_PER_NS = 40,
  parameter int unsigned NPADS      = 2,
  parameter int unsigned HALF_US    = 6,
  parameter int unsigned POLL_US    = 16667
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   dclock_o,
  output logic                   dlatch_o,
  input  logic [NPADS-1:0]       sdata,
  output logic [16*NPADS-1:0]    vdata_o,
  output logic                   valid_o,
  output logic                   busy_o
);

  localparam int unsigned HALF_CYC = HALF_US * 1000 / CLK_PER_NS;
  localparam int unsigned POLL_CYC = POLL_US * 1000 / CLK_PER_NS;
  localparam int unsigned CNT_W    = (2 * HALF_CYC > 1) ? $clog2(2 * HALF_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    BIT_LO,
    BIT_HI,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_n;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                bit_k;
  logic                      phase_last;
  logic                      poll_hit;
  logic [NPADS-1:0]          sync1;
  logic [NPADS-1:0]          sync2;
  logic [NPADS-1:0][15:0]    raw;
`ifdef SNESPAD_DEBOUNCE_EN
  logic [NPADS-1:0][15:0]    prev;
`endif

  // Two-flop synchroniser per pad line; lines idle high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= sdata;
      sync2 <= sync1;
    end
  end

  // Auto-poll timer: free-running, restarted whenever a frame starts, and
  // parked at its terminal count if that is reached while a frame runs.
  generate
    if (POLL_CYC > 0) begin : g_poll
      localparam int unsigned POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
      logic [POLL_W-1:0] poll_cnt;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          poll_cnt <= '0;
        end else if (state == IDLE && state_n == LATCH) begin
          poll_cnt <= '0;
        end else if (poll_cnt != POLL_W'(POLL_CYC - 1)) begin
          poll_cnt <= poll_cnt + 1'b1;
        end
      end

      assign poll_hit = (state == IDLE) && (poll_cnt == POLL_W'(POLL_CYC - 1));
    end else begin : g_nopoll
      assign poll_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    if (state == LATCH)
      phase_last = (cnt == CNT_W'(2 * HALF_CYC - 1));
    else
      phase_last = (cnt == CNT_W'(HALF_CYC - 1));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i || poll_hit) state_n = LATCH;
      LATCH:   if (phase_last) state_n = BIT_LO;
      BIT_LO:  if (phase_last) state_n = BIT_HI;
      BIT_HI:  if (phase_last) state_n = (bit_k == 4'd15) ? DONE : BIT_LO;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pad-facing and status outputs are registered from the next state so
  // they change exactly with the state register and never glitch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_k    <= '0;
      raw      <= '0;
      dclock_o <= 1'b1;
      dlatch_o <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      vdata_o  <= '0;
`ifdef SNESPAD_DEBOUNCE_EN
      prev     <= '0;
`endif
    end else begin
      state    <= state_n;
      dclock_o <= (state_n != BIT_LO);
      dlatch_o <= (state_n == LATCH);
      busy_o   <= (state_n != IDLE);
      valid_o  <= (state_n == DONE);

      if (state == IDLE || state_n != state)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (state == LATCH)
        bit_k <= '0;
      else if (state == BIT_HI && phase_last)
        bit_k <= bit_k + 1'b1;

      if (state == BIT_LO && phase_last) begin
        for (int unsigned p = 0; p < NPADS; p++)
          raw[p][bit_k] <= sync2[p];
      end

      // Words are loaded on entry to DONE so they are already stable while
      // valid_o is high during the DONE cycle.
      if (state == BIT_HI && state_n == DONE) begin
        for (int unsigned p = 0; p < NPADS; p++) begin
`ifdef SNESPAD_DEBOUNCE_EN
          if (raw[p] == prev[p])
            vdata_o[16*p +: 16] <= ~raw[p];
          prev[p] <= raw[p];
`else
          vdata_o[16*p +: 16] <= ~raw[p];
`endif
        end
      end
    end
  end

endmodule
